// File: rtl/mips_core_pkg.sv
// Shared types and constants for the fetch redirect logic.
package mips_core_pkg;

  localparam int unsigned FLUSH_CNT_W = 3;

  typedef logic [FLUSH_CNT_W-1:0] flush_cnt_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    JMP  = 2'd1,
    BR   = 2'd2,
    EXC  = 2'd3
  } redirect_src_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    FLUSH   = 2'd2
  } redirect_state_e;

  // One-hot grant bit positions.
  localparam int unsigned GNT_JMP = 0;
  localparam int unsigned GNT_BR  = 1;
  localparam int unsigned GNT_EXC = 2;

  // Fetch targets are word aligned; the low two bits are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_redirect_arb.sv
// Fixed-priority redirect selection: exc > br > jmp.
module fetch_redirect_arb
  import mips_core_pkg::*;
(
  input  logic          exc_valid,
  input  logic [31:0]   exc_pc,
  input  logic          br_valid,
  input  logic [31:0]   br_pc,
  input  logic          jmp_valid,
  input  logic [31:0]   jmp_pc,
  output redirect_src_e src,
  output logic [31:0]   pc,
  output logic [2:0]    grant
);

  // Pick the highest-priority valid request.
  always_comb begin
    src   = NONE;
    pc    = '0;
    grant = '0;
    if (exc_valid) begin
      src            = EXC;
      pc             = exc_pc;
      grant[GNT_EXC] = 1'b1;
    end else if (br_valid) begin
      src           = BR;
      pc            = br_pc;
      grant[GNT_BR] = 1'b1;
    end else if (jmp_valid) begin
      src            = JMP;
      pc             = jmp_pc;
      grant[GNT_JMP] = 1'b1;
    end
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect controller: arbitrates redirect requests, issues PC loads,
// holds a redirect while fetch is stalled, and flushes IF/ID afterwards.
module fetch_redirect_ctrl
  import mips_core_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_in,
  input  logic        exc_valid,
  input  logic [31:0] exc_pc,
  input  logic        br_valid,
  input  logic [31:0] br_pc,
  input  logic        jmp_valid,
  input  logic [31:0] jmp_pc,
  output logic        exc_ack,
  output logic        br_ack,
  output logic        jmp_ack,
  output logic        load_we,
  output logic [31:0] load_pc,
  output logic        flush,
  output logic        busy
);

  localparam flush_cnt_t FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES);

  redirect_state_e state, state_nxt;
  flush_cnt_t      cnt, cnt_nxt;
  logic [31:0]     pend_pc, pend_pc_nxt;
  redirect_src_e   pend_src, pend_src_nxt;

  redirect_src_e   win_src;
  logic [31:0]     win_pc;
  logic [2:0]      win_grant;

  logic [2:0]      ack_c;
  logic            load_we_c;
  logic [31:0]     load_pc_c;
  logic            exc_override;

  fetch_redirect_arb u_arb (
    .exc_valid (exc_valid),
    .exc_pc    (exc_pc),
    .br_valid  (br_valid),
    .br_pc     (br_pc),
    .jmp_valid (jmp_valid),
    .jmp_pc    (jmp_pc),
    .src       (win_src),
    .pc        (win_pc),
    .grant     (win_grant)
  );

  assign exc_override = exc_valid && (pend_src != EXC);

  // Next-state, ack and PC-load decode.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    pend_pc_nxt  = pend_pc;
    pend_src_nxt = pend_src;
    ack_c        = '0;
    load_we_c    = 1'b0;
    load_pc_c    = '0;
    unique case (state)
      IDLE: begin
        if (win_src != NONE) begin
          ack_c = win_grant;
          if (!stall_in) begin
            load_we_c = 1'b1;
            load_pc_c = align_pc(win_pc);
            state_nxt = FLUSH;
            cnt_nxt   = FLUSH_LOAD;
          end else begin
            pend_pc_nxt  = align_pc(win_pc);
            pend_src_nxt = win_src;
            state_nxt    = PENDING;
          end
        end
      end
      PENDING: begin
        if (stall_in) begin
          if (exc_override) begin
            ack_c[GNT_EXC] = 1'b1;
            pend_pc_nxt    = align_pc(exc_pc);
            pend_src_nxt   = EXC;
          end
        end else begin
          load_we_c    = 1'b1;
          state_nxt    = FLUSH;
          cnt_nxt      = FLUSH_LOAD;
          pend_pc_nxt  = '0;
          pend_src_nxt = NONE;
          if (exc_override) begin
            ack_c[GNT_EXC] = 1'b1;
            load_pc_c      = align_pc(exc_pc);
          end else begin
            load_pc_c = pend_pc;
          end
        end
      end
      FLUSH: begin
        // Only exceptions are taken here; br/jmp are wrong-path and wait.
        if (exc_valid) begin
          ack_c[GNT_EXC] = 1'b1;
          cnt_nxt        = FLUSH_LOAD;
          if (!stall_in) begin
            load_we_c = 1'b1;
            load_pc_c = align_pc(exc_pc);
          end else begin
            pend_pc_nxt  = align_pc(exc_pc);
            pend_src_nxt = EXC;
            state_nxt    = PENDING;
          end
        end else if (!stall_in) begin
          // Leaving on the final decrement gives exactly FLUSH_CYCLES
          // unstalled flush cycles.
          if (cnt <= flush_cnt_t'(1)) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt - flush_cnt_t'(1);
          end
        end
      end
      default: begin
        state_nxt    = IDLE;
        cnt_nxt      = '0;
        pend_pc_nxt  = '0;
        pend_src_nxt = NONE;
      end
    endcase
  end

  // State, pending register and flush counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      pend_pc  <= '0;
      pend_src <= NONE;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      pend_pc  <= pend_pc_nxt;
      pend_src <= pend_src_nxt;
    end
  end

  assign exc_ack = rst_n & ack_c[GNT_EXC];
  assign br_ack  = rst_n & ack_c[GNT_BR];
  assign jmp_ack = rst_n & ack_c[GNT_JMP];
  assign load_we = rst_n & load_we_c;
  assign load_pc = load_pc_c;
  assign flush   = (state == FLUSH);
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl (FLUSH_CYCLES=1 and =3 instances).
module tb_fetch_redirect_ctrl;

  logic        clk;
  logic        rst_n;
  logic        stall_in;
  logic        exc_valid, br_valid, jmp_valid;
  logic [31:0] exc_pc, br_pc, jmp_pc;

  logic        exc_ack, br_ack, jmp_ack, load_we, flush, busy;
  logic [31:0] load_pc;
  logic        exc_ack3, br_ack3, jmp_ack3, load_we3, flush3, busy3;
  logic [31:0] load_pc3;

  int vectors = 0;
  int errors  = 0;

  fetch_redirect_ctrl #(.FLUSH_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in),
    .exc_valid(exc_valid), .exc_pc(exc_pc),
    .br_valid(br_valid), .br_pc(br_pc),
    .jmp_valid(jmp_valid), .jmp_pc(jmp_pc),
    .exc_ack(exc_ack), .br_ack(br_ack), .jmp_ack(jmp_ack),
    .load_we(load_we), .load_pc(load_pc), .flush(flush), .busy(busy)
  );

  fetch_redirect_ctrl #(.FLUSH_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in),
    .exc_valid(exc_valid), .exc_pc(exc_pc),
    .br_valid(br_valid), .br_pc(br_pc),
    .jmp_valid(jmp_valid), .jmp_pc(jmp_pc),
    .exc_ack(exc_ack3), .br_ack(br_ack3), .jmp_ack(jmp_ack3),
    .load_we(load_we3), .load_pc(load_pc3), .flush(flush3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are changed 1ns after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall_in  = 1'b0;
    exc_valid = 1'b0; exc_pc = '0;
    br_valid  = 1'b0; br_pc  = '0;
    jmp_valid = 1'b0; jmp_pc = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    cyc();
    cyc();
    exc_valid = 1'b1; exc_pc = 32'h8000_0180;
    br_valid  = 1'b1; br_pc  = 32'h104;
    jmp_valid = 1'b1; jmp_pc = 32'h40;
    #2;
    vectors++; if ({exc_ack, br_ack, jmp_ack} !== 3'b000) begin errors++; $display("FAIL rst_acks got %b exp 000", {exc_ack, br_ack, jmp_ack}); end
    vectors++; if (load_we !== 1'b0) begin errors++; $display("FAIL rst_load_we got %b exp 0", load_we); end
    cyc();
    vectors++; if ({busy, flush} !== 2'b00) begin errors++; $display("FAIL rst_busy_flush got %b exp 00", {busy, flush}); end
    vectors++; if ({busy3, flush3, load_we3} !== 3'b000) begin errors++; $display("FAIL rst3_state got %b exp 000", {busy3, flush3, load_we3}); end
    clear_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_branch();
    do_reset();
    br_valid = 1'b1; br_pc = 32'h0000_0104;
    #2;
    vectors++; if ({exc_ack, br_ack, jmp_ack} !== 3'b010) begin errors++; $display("FAIL br_acks got %b exp 010", {exc_ack, br_ack, jmp_ack}); end
    vectors++; if (load_we !== 1'b1) begin errors++; $display("FAIL br_load_we got %b exp 1", load_we); end
    vectors++; if (load_pc !== 32'h0000_0104) begin errors++; $display("FAIL br_load_pc got %h exp 00000104", load_pc); end
    cyc();
    br_valid = 1'b0;
    #2;
    vectors++; if ({flush, busy, load_we} !== 3'b110) begin errors++; $display("FAIL br_flush got %b exp 110", {flush, busy, load_we}); end
    cyc();
    #2;
    vectors++; if ({flush, busy} !== 2'b00) begin errors++; $display("FAIL br_idle got %b exp 00", {flush, busy}); end
  endtask

  task automatic test_priority();
    do_reset();
    exc_valid = 1'b1; exc_pc = 32'h8000_0180;
    br_valid  = 1'b1; br_pc  = 32'h104;
    jmp_valid = 1'b1; jmp_pc = 32'h40;
    #2;
    vectors++; if ({exc_ack, br_ack, jmp_ack} !== 3'b100) begin errors++; $display("FAIL prio_acks got %b exp 100", {exc_ack, br_ack, jmp_ack}); end
    vectors++; if (load_pc !== 32'h8000_0180) begin errors++; $display("FAIL prio_load_pc got %h exp 80000180", load_pc); end
    // br only (exc dropped) while still idle on a fresh reset: br beats jmp
    do_reset();
    br_valid  = 1'b1; br_pc  = 32'h208;
    jmp_valid = 1'b1; jmp_pc = 32'h40;
    #2;
    vectors++; if ({exc_ack, br_ack, jmp_ack} !== 3'b010) begin errors++; $display("FAIL prio_br_jmp got %b exp 010", {exc_ack, br_ack, jmp_ack}); end
    vectors++; if (load_pc !== 32'h208) begin errors++; $display("FAIL prio_br_pc got %h exp 00000208", load_pc); end
  endtask

  task automatic test_stall();
    do_reset();
    stall_in = 1'b1; jmp_valid = 1'b1; jmp_pc = 32'h40;
    #2;
    vectors++; if ({jmp_ack, load_we} !== 2'b10) begin errors++; $display("FAIL stall_c0 ack/we got %b exp 10", {jmp_ack, load_we}); end
    cyc();
    jmp_valid = 1'b0;
    #2;
    vectors++; if ({load_we, busy, flush} !== 3'b010) begin errors++; $display("FAIL stall_c1 got %b exp 010", {load_we, busy, flush}); end
    cyc();
    #2;
    vectors++; if (load_we !== 1'b0) begin errors++; $display("FAIL stall_c2 load_we got %b exp 0", load_we); end
    cyc();
    stall_in = 1'b0;
    #2;
    vectors++; if (load_we !== 1'b1) begin errors++; $display("FAIL stall_rel load_we got %b exp 1", load_we); end
    vectors++; if (load_pc !== 32'h40) begin errors++; $display("FAIL stall_rel load_pc got %h exp 00000040", load_pc); end
    vectors++; if ({exc_ack, br_ack, jmp_ack} !== 3'b000) begin errors++; $display("FAIL stall_rel acks got %b exp 000", {exc_ack, br_ack, jmp_ack}); end
    cyc();
    #2;
    vectors++; if ({flush, load_we} !== 2'b10) begin errors++; $display("FAIL stall_flush got %b exp 10", {flush, load_we}); end
  endtask

  task automatic test_override();
    do_reset();
    stall_in = 1'b1; br_valid = 1'b1; br_pc = 32'h200;
    #2;
    vectors++; if (br_ack !== 1'b1) begin errors++; $display("FAIL ovr_br_ack got %b exp 1", br_ack); end
    cyc();
    br_pc = 32'h300;
    exc_valid = 1'b1; exc_pc = 32'h8000_0180;
    #2;
    vectors++; if ({exc_ack, br_ack, load_we} !== 3'b100) begin errors++; $display("FAIL ovr_pend got %b exp 100", {exc_ack, br_ack, load_we}); end
    cyc();
    exc_valid = 1'b0; br_valid = 1'b0; stall_in = 1'b0;
    #2;
    vectors++; if (load_we !== 1'b1) begin errors++; $display("FAIL ovr_rel load_we got %b exp 1", load_we); end
    vectors++; if (load_pc !== 32'h8000_0180) begin errors++; $display("FAIL ovr_rel load_pc got %h exp 80000180", load_pc); end
    cyc();
    #2;
    vectors++; if ({load_we, flush} !== 2'b01) begin errors++; $display("FAIL ovr_after got %b exp 01", {load_we, flush}); end
    // Exception arriving in the releasing cycle replaces the pending jmp.
    do_reset();
    stall_in = 1'b1; jmp_valid = 1'b1; jmp_pc = 32'h40;
    cyc();
    jmp_valid = 1'b0; stall_in = 1'b0;
    exc_valid = 1'b1; exc_pc = 32'h0000_1000;
    #2;
    vectors++; if ({exc_ack, jmp_ack, load_we} !== 3'b101) begin errors++; $display("FAIL ovr_rel_exc got %b exp 101", {exc_ack, jmp_ack, load_we}); end
    vectors++; if (load_pc !== 32'h0000_1000) begin errors++; $display("FAIL ovr_rel_exc pc got %h exp 00001000", load_pc); end
    // Pending exc is not replaced by a second exc while stalled.
    do_reset();
    stall_in = 1'b1; exc_valid = 1'b1; exc_pc = 32'h8000_0000;
    cyc();
    exc_pc = 32'h8000_0100;
    #2;
    vectors++; if (exc_ack !== 1'b0) begin errors++; $display("FAIL exc_keep ack got %b exp 0", exc_ack); end
    cyc();
    exc_valid = 1'b0; stall_in = 1'b0;
    #2;
    vectors++; if (load_pc !== 32'h8000_0000) begin errors++; $display("FAIL exc_keep pc got %h exp 80000000", load_pc); end
  endtask

  task automatic test_flush_exc();
    do_reset();
    br_valid = 1'b1; br_pc = 32'h104;
    cyc();
    exc_valid = 1'b1; exc_pc = 32'h8000_0180;
    #2;
    vectors++; if ({exc_ack, br_ack, load_we, flush} !== 4'b1011) begin errors++; $display("FAIL fexc_issue got %b exp 1011", {exc_ack, br_ack, load_we, flush}); end
    vectors++; if (load_pc !== 32'h8000_0180) begin errors++; $display("FAIL fexc_pc got %h exp 80000180", load_pc); end
    cyc();
    exc_valid = 1'b0;
    #2;
    vectors++; if ({flush, br_ack} !== 2'b10) begin errors++; $display("FAIL fexc_reload got %b exp 10", {flush, br_ack}); end
    cyc();
    #2;
    vectors++; if ({flush, busy, br_ack, load_we} !== 4'b0011) begin errors++; $display("FAIL fexc_idle got %b exp 0011", {flush, busy, br_ack, load_we}); end
    br_valid = 1'b0;
  endtask

  task automatic test_flush3();
    do_reset();
    br_valid = 1'b1; br_pc = 32'h104;
    #2;
    vectors++; if ({br_ack3, load_we3} !== 2'b11) begin errors++; $display("FAIL f3_issue got %b exp 11", {br_ack3, load_we3}); end
    cyc();
    br_valid = 1'b0; jmp_valid = 1'b1; jmp_pc = 32'h40;
    for (int i = 0; i < 4; i++) begin
      stall_in = (i == 1);
      #2;
      vectors++; if ({flush3, jmp_ack3, load_we3} !== 3'b100) begin errors++; $display("FAIL f3_flush[%0d] got %b exp 100", i, {flush3, jmp_ack3, load_we3}); end
      cyc();
    end
    stall_in = 1'b0;
    #2;
    vectors++; if ({flush3, busy3, jmp_ack3, load_we3} !== 4'b0011) begin errors++; $display("FAIL f3_idle got %b exp 0011", {flush3, busy3, jmp_ack3, load_we3}); end
    jmp_valid = 1'b0;
  endtask

  task automatic test_reset_pending();
    do_reset();
    stall_in = 1'b1; br_valid = 1'b1; br_pc = 32'h200;
    cyc();
    br_valid = 1'b0;
    rst_n = 1'b0;
    exc_valid = 1'b1; exc_pc = 32'h8000_0180;
    #2;
    vectors++; if ({exc_ack, load_we} !== 2'b00) begin errors++; $display("FAIL rp_in_reset got %b exp 00", {exc_ack, load_we}); end
    cyc();
    exc_valid = 1'b0; rst_n = 1'b1; stall_in = 1'b0;
    #2;
    vectors++; if ({load_we, busy, flush} !== 3'b000) begin errors++; $display("FAIL rp_release got %b exp 000", {load_we, busy, flush}); end
    cyc();
    #2;
    vectors++; if ({load_we, busy} !== 2'b00) begin errors++; $display("FAIL rp_after got %b exp 00", {load_we, busy}); end
  endtask

  task automatic test_misalign();
    do_reset();
    br_valid = 1'b1; br_pc = 32'h0000_0107;
    #2;
    vectors++; if (load_pc !== 32'h0000_0104) begin errors++; $display("FAIL mis_br got %h exp 00000104", load_pc); end
    do_reset();
    stall_in = 1'b1; exc_valid = 1'b1; exc_pc = 32'h8000_0183;
    cyc();
    exc_valid = 1'b0; stall_in = 1'b0;
    #2;
    vectors++; if (load_pc !== 32'h8000_0180) begin errors++; $display("FAIL mis_pend got %h exp 80000180", load_pc); end
    br_valid = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_branch();
    test_priority();
    test_stall();
    test_override();
    test_flush_exc();
    test_flush3();
    test_reset_pending();
    test_misalign();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_ctrl.md
FETCH_REDIRECT_CTRL -- requirements
Module: fetch_redirect_ctrl

Interface
REQ-001 Parameter: FLUSH_CYCLES, 1, number of cycles o_flush is held after a redirect issues (legal 1..7).
REQ-002 Clock and reset: clk and rst_n; rst_n is synchronous and active-low.
REQ-003 clk  in  1  clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 stall_in  in  1  fetch hazard stall; the PC must not be loaded this cycle.
REQ-006 exc_valid / exc_pc  in  1 / 32  exception or trap redirect request and its target.
REQ-007 br_valid / br_pc  in  1 / 32  EX-stage branch-mispredict redirect and its target.
REQ-008 jmp_valid / jmp_pc  in  1 / 32  decode-stage jump redirect and its target.
REQ-009 exc_ack, br_ack, jmp_ack  out  1 each  request consumed this cycle; the requester drops or advances.
REQ-010 load_we / load_pc  out  1 / 32  PC load command to fetch; load_pc[1:0] is always 2'b00.
REQ-011 flush  out  1  kill the instruction currently in IF/ID.
REQ-012 busy  out  1  high whenever the state is PENDING or FLUSH.

Function
REQ-013 Source priority is exc > br > jmp; only one request is acked per cycle, and only the winner.
REQ-014 State machine states are IDLE, PENDING and FLUSH.
REQ-015 IDLE, any request valid, stall_in=0:
  - Winner is acked.
  - load_we=1 and load_pc=target in the same cycle (zero latency).
  - Next state is FLUSH with the counter set to FLUSH_CYCLES.
REQ-016 IDLE, any request valid, stall_in=1:
  - Winner is acked.
  - Target and source are latched into the pending register.
  - load_we=0; next state is PENDING.
REQ-017 PENDING, stall_in=1: load_we=0.
  - A new exc request is acked and overwrites the pending register, unless the pending source is already exc.
  - br and jmp requests are not acked.
REQ-018 PENDING, stall_in=0: load_we=1 with the pending PC; next state is FLUSH.
  - If exc_valid is high in the same cycle and the pending source is not exc, the new exc target is issued instead, exc is acked, and the old pending entry is discarded.
REQ-019 FLUSH:
  - flush=1 every cycle; the counter decrements only when stall_in=0.
  - The state returns to IDLE in the cycle after the counter reaches 0.
  - br and jmp requests are never acked in FLUSH (they are wrong-path).
REQ-020 FLUSH, exc request:
  - Acked and handled per REQ-015/016 (issue or latch into PENDING).
  - The flush counter reloads to FLUSH_CYCLES.
REQ-021 load_we is never asserted while stall_in=1.
REQ-022 At most one load_we pulse is generated per acked request; a request is never acked without eventually causing a load_we, unless it is superseded by an exc.
REQ-023 Target bits [1:0] are cleared before output; the remaining bits pass unchanged.
REQ-024 Outputs depend combinationally on current-cycle inputs only through the priority select and stall_in; all other outputs are registered state.

Reset
REQ-025 With rst_n=0 at a clock edge, the next state is:
  - IDLE, counter 0, pending register 0.
  - Outputs load_we, flush, busy and all acks are 0.
REQ-026 Reset mid-PENDING or mid-FLUSH discards the pending redirect; no load_we is issued after reset.
REQ-027 While rst_n=0, all acks are forced to 0 regardless of request inputs.

Structure
REQ-028 The following belong in mips_core_pkg:
  - redirect_src_e enum: NONE, JMP, BR, EXC.
  - redirect_state_e enum: IDLE, PENDING, FLUSH.
  - Flush counter width constant (3 bits).
REQ-029 Priority selection is a purely combinational sub-module, fetch_redirect_arb.
  - Inputs: the three valid/pc pairs.
  - Outputs: winner source, winner PC, one-hot grant.
REQ-030 The FSM, pending register and flush counter are held in fetch_redirect_ctrl.

Verification
REQ-031 IDLE, stall_in=0, br_valid=1, br_pc=0x0000_0104 -> same cycle: br_ack=1, load_we=1, load_pc=0x0000_0104; next cycle flush=1, busy=1; IDLE after 1 flush cycle.
REQ-032 exc_valid, br_valid and jmp_valid all 1 in IDLE, with exc_pc=0x8000_0180 -> only exc_ack=1, load_pc=0x8000_0180.
REQ-033 Stall case:
  - Stimulus: stall_in=1 for 3 cycles with jmp_pc=0x40 requested in cycle 0.
  - Response: jmp_ack in cycle 0; load_we=0 for cycles 0-2; load_we=1, load_pc=0x40 in the first cycle stall_in=0.
REQ-034 Override while pending:
  - Stimulus: PENDING holding br 0x200; exc 0x8000_0180 arrives while stall_in=1.
  - Response: exc_ack=1; on release, load_pc=0x8000_0180; 0x200 is never issued.
REQ-035 FLUSH_CYCLES=3, br issued, then jmp_valid held high -> flush=1 for 3 unstalled cycles, no jmp_ack during that time, jmp_ack in the first IDLE cycle.
REQ-036 rst_n=0 asserted in PENDING with stall_in=1, then released with stall_in=0 -> load_we stays 0, busy=0, state IDLE.
REQ-037 Misaligned target br_pc=0x0000_0107 -> load_pc=0x0000_0104.
